// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: op encodings, data width
// and the sequencer state type.
package alu_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Command front-end for the 4-bit ALU: registers operands/select, captures the
// ALU result one cycle later, keeps an accumulator and returns a response.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    input  logic              cmd_acc_wr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic [DATA_W-1:0] acc,
    output logic [7:0]        op_count
);

    state_t state;
    logic   acc_wr_q;

    assign cmd_ready = (state == IDLE);

    // The accumulator is only written on the EXEC->RESP edge, so a command
    // accepted afterwards always sees the previous result as operand A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_wr_q  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            acc       <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_sel  <= cmd_op;
                        alu_a    <= cmd_use_acc ? acc : cmd_a;
                        alu_b    <= cmd_b;
                        acc_wr_q <= cmd_acc_wr;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_carry <= alu_carry;
                    rsp_zero  <= (alu_y == '0);
                    if (acc_wr_q) begin
                        acc <= alu_y;
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU wired beside it.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_use_acc;
    logic       cmd_acc_wr;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_y;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_y;
    logic       rsp_carry;
    logic       rsp_zero;
    logic [3:0] acc;
    logic [7:0] op_count;

    int tests;
    int failures;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_use_acc(cmd_use_acc),
        .cmd_acc_wr (cmd_acc_wr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_y      (alu_y),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_y      (rsp_y),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .acc        (acc),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the team ALU the parent normally instantiates.
    always_comb begin
        logic [4:0] sum;
        sum       = '0;
        alu_y     = '0;
        alu_carry = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                sum       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y     = sum[3:0];
                alu_carry = sum[4];
            end
            OP_SUB: begin
                alu_y     = alu_a - alu_b;
                alu_carry = (alu_a < alu_b);
            end
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_XOR:  alu_y = alu_a ^ alu_b;
            OP_NOT:  alu_y = ~alu_a;
            OP_SHL:  alu_y = alu_b << 1;
            default: alu_y = alu_b >> 1;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issues one command from a negedge and stops on the negedge after the
    // response appears, checking the operand registers and response fields.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic use_acc, input logic acc_wr,
                                 input logic [3:0] exp_a, input logic [3:0] exp_y, input logic exp_c);
        checkOutput({tag, ".ready_idle"}, cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        cmd_acc_wr  = acc_wr;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput({tag, ".alu_sel"}, alu_sel, op);
        checkOutput({tag, ".alu_a"}, alu_a, exp_a);
        checkOutput({tag, ".alu_b"}, alu_b, b);
        checkOutput({tag, ".exec_valid"}, rsp_valid, 0);
        checkOutput({tag, ".exec_ready"}, cmd_ready, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, ".rsp_valid"}, rsp_valid, 1);
        checkOutput({tag, ".rsp_y"}, rsp_y, exp_y);
        checkOutput({tag, ".rsp_carry"}, rsp_carry, exp_c);
        checkOutput({tag, ".rsp_zero"}, rsp_zero, (exp_y == 4'd0));
    endtask

    task automatic handshake(input string tag, input logic [7:0] exp_count);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({tag, ".valid_drop"}, rsp_valid, 0);
        checkOutput({tag, ".ready_back"}, cmd_ready, 1);
        checkOutput({tag, ".op_count"}, op_count, exp_count);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".cmd_ready"}, cmd_ready, 1);
        checkOutput({tag, ".rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, ".acc"}, acc, 0);
        checkOutput({tag, ".op_count"}, op_count, 0);
        checkOutput({tag, ".alu_a"}, alu_a, 0);
        checkOutput({tag, ".alu_b"}, alu_b, 0);
        checkOutput({tag, ".alu_sel"}, alu_sel, 0);
        checkOutput({tag, ".rsp_y"}, rsp_y, 0);
        checkOutput({tag, ".rsp_carry"}, rsp_carry, 0);
        checkOutput({tag, ".rsp_zero"}, rsp_zero, 0);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tests       = 0;
        failures    = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b1;
        cmd_op      = OP_XOR;
        cmd_a       = 4'hF;
        cmd_b       = 4'hF;
        cmd_use_acc = 1'b0;
        cmd_acc_wr  = 1'b1;
        rsp_ready   = 1'b0;

        // Commands offered while reset is held must be ignored.
        repeat (3) @(negedge clk);
        checkResetState("reset");
        cmd_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        checkResetState("post_reset");

        applyStimulus("add_9_8", OP_ADD, 4'd9, 4'd8, 1'b0, 1'b0, 4'd9, 4'd1, 1'b1);
        handshake("add_9_8", 8'd1);
        applyStimulus("sub_3_5", OP_SUB, 4'd3, 4'd5, 1'b0, 1'b0, 4'd3, 4'hE, 1'b1);
        handshake("sub_3_5", 8'd2);
        applyStimulus("sub_5_3", OP_SUB, 4'd5, 4'd3, 1'b0, 1'b0, 4'd5, 4'd2, 1'b0);
        handshake("sub_5_3", 8'd3);

        // Accumulator chain from a fresh reset.
        pulseReset();
        checkResetState("chain_reset");
        applyStimulus("chain_add", OP_ADD, 4'hC, 4'd7, 1'b1, 1'b1, 4'd0, 4'd7, 1'b0);
        checkOutput("chain_add.acc", acc, 7);
        handshake("chain_add", 8'd1);
        applyStimulus("chain_xor", OP_XOR, 4'hC, 4'd7, 1'b1, 1'b1, 4'd7, 4'd0, 1'b0);
        checkOutput("chain_xor.acc", acc, 0);
        handshake("chain_xor", 8'd2);
        applyStimulus("chain_or", OP_OR, 4'd5, 4'd2, 1'b0, 1'b0, 4'd5, 4'd7, 1'b0);
        checkOutput("chain_or.acc", acc, 0);
        handshake("chain_or", 8'd3);

        // Back-pressure: response must hold while a competing command waits.
        applyStimulus("stall_and", OP_AND, 4'hF, 4'd6, 1'b0, 1'b0, 4'hF, 4'd6, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_a     = 4'd1;
        cmd_b     = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall.rsp_valid", rsp_valid, 1);
            checkOutput("stall.rsp_y", rsp_y, 6);
            checkOutput("stall.cmd_ready", cmd_ready, 0);
            checkOutput("stall.alu_sel", alu_sel, OP_AND);
            checkOutput("stall.alu_a", alu_a, 4'hF);
        end
        cmd_valid = 1'b0;
        handshake("stall", 8'd4);
        @(negedge clk);
        checkOutput("stall.no_second", rsp_valid, 0);
        checkOutput("stall.count_hold", op_count, 4);

        // Reset while a command is executing discards it.
        applyStimulus("pre_abort", OP_ADD, 4'd3, 4'd4, 1'b0, 1'b1, 4'd3, 4'd7, 1'b0);
        handshake("pre_abort", 8'd5);
        checkOutput("pre_abort.acc", acc, 7);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_a     = 4'd1;
        cmd_b     = 4'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("abort.in_exec", cmd_ready, 0);
        rst = 1'b1;
        #1;
        checkResetState("abort_async");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort.no_rsp", rsp_valid, 0);
        end
        applyStimulus("after_abort", OP_ADD, 4'd9, 4'd8, 1'b0, 1'b0, 4'd9, 4'd1, 1'b1);
        handshake("after_abort", 8'd1);

        applyStimulus("not_5", OP_NOT, 4'd5, 4'd0, 1'b0, 1'b0, 4'd5, 4'hA, 1'b0);
        handshake("not_5", 8'd2);
        applyStimulus("shl_9", OP_SHL, 4'd0, 4'd9, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0);
        handshake("shl_9", 8'd3);
        applyStimulus("shr_9", OP_SHR, 4'd0, 4'd9, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0);
        handshake("shr_9", 8'd4);

        // Drive op_count through 255 and across the wrap.
        for (int i = 5; i <= 256; i++) begin
            logic [3:0] va;
            logic [7:0] cnt;
            va  = 4'(i);
            cnt = 8'(i);
            applyStimulus("wrap", OP_OR, va, 4'd0, 1'b0, 1'b0, va, va, 1'b0);
            handshake("wrap", cnt);
        end
        checkOutput("wrap.final", op_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
